im_loader: RTL and testbench

Byte-stream writer that fills the 1024 x 16-bit instruction memory ahead of execution. It accepts a length-prefixed program image over a valid/ready byte channel, assembles big-endian 16-bit instruction words and issues one write per word at consecutive word addresses from `BASE_ADDR`. It holds the CPU (`cpu_hold`) while loading and signals completion, so the instruction memory's read side sees only complete images.

---
 rtl/im_pkg.sv | 21 ++
 rtl/im_loader.sv | 189 ++++++++++++++++++
 tb/tb_im_loader.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/im_pkg.sv
// im_pkg: constants shared by the instruction-memory loader and its users.
//   IM_DEPTH   - instruction memory depth in words
//   IM_WORD_W  - instruction word width in bits
//   IM_ADDR_W  - word-address width
//   ld_state_t - loader FSM state encoding, also visible on the debug port
package im_pkg;

  localparam int IM_DEPTH  = 1024;
  localparam int IM_WORD_W = 16;
  localparam int IM_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_FINISH  = 3'd5
  } ld_state_t;

endpackage

// File: rtl/im_loader.sv
// im_loader: fills the instruction memory from a length-prefixed byte stream.
//
// Stream: LEN_HI, LEN_LO (word count N, big-endian), then N words, each sent
// high byte first. Word i is written to BASE_ADDR + i. An empty or oversized
// image produces no writes; oversized also raises the sticky err flag.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   start               - begin a load; only looked at while idle
//   in_valid/in_data    - byte channel from the host
//   in_ready            - loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data - one-cycle write strobe to instruction memory
//   busy, cpu_hold      - high for the whole load
//   done                - one-cycle pulse once the load has finished
//   err                 - sticky, last load's length was illegal
//   dbg_state           - current FSM state (ld_state_t encoding)
//
// Handshake: a byte moves on every rising edge where in_valid && in_ready are
// both high; in_valid may come and go freely, and when no byte moves the FSM
// holds its state. in_ready depends only on the FSM state, never on in_valid.
//
// Every output is a flop. Each flop is loaded with the value the FSM computes
// for the cycle that follows, so outputs change only on the clock edge.
module im_loader
  import im_pkg::*;
#(
  parameter int ADDR_W    = IM_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [IM_WORD_W-1:0] wr_data,
  output logic                 busy,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           dbg_state
);

  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam logic [31:0] MAX_LEN = 32'((1 << ADDR_W) - BASE_ADDR);

  ld_state_t              r_state;
  logic [7:0]             r_hi;
  logic [15:0]            r_len;
  logic [ADDR_W-1:0]      r_idx;
  logic                   r_in_ready;
  logic                   r_wr_en;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic [IM_WORD_W-1:0]   r_wr_data;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  ld_state_t              w_state_nxt;
  logic [7:0]             w_hi_nxt;
  logic [15:0]            w_len_nxt;
  logic [ADDR_W-1:0]      w_idx_nxt;
  logic                   w_in_ready_nxt;
  logic                   w_wr_en_nxt;
  logic [ADDR_W-1:0]      w_wr_addr_nxt;
  logic [IM_WORD_W-1:0]   w_wr_data_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_err_nxt;

  logic                   w_xfer;
  logic [15:0]            w_len_cur;
  logic [16:0]            w_idx_p1;

  assign w_xfer    = in_valid && r_in_ready;
  assign w_len_cur = {r_hi, in_data};
  // One bit wider than the length so a full 2^ADDR_W-word image terminates.
  assign w_idx_p1  = 17'(r_idx) + 17'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hi       <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hi       <= w_hi_nxt;
      r_len      <= w_len_nxt;
      r_idx      <= w_idx_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hi_nxt      = r_hi;
    w_len_nxt     = r_len;
    w_idx_nxt     = r_idx;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_err_nxt     = r_err;

    case (r_state)
      ST_IDLE: begin
        // done is high during the first idle cycle; busy drops with it.
        if (r_done) w_busy_nxt = 1'b0;
        if (start) begin
          w_state_nxt = ST_LEN_HI;
          w_err_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (w_xfer) begin
          w_hi_nxt    = in_data;
          w_state_nxt = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (w_xfer) begin
          w_len_nxt = w_len_cur;
          w_idx_nxt = '0;
          if (w_len_cur == 16'd0) begin
            w_state_nxt = ST_FINISH;
          end else if (32'(w_len_cur) > MAX_LEN) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (w_xfer) begin
          w_hi_nxt    = in_data;
          w_state_nxt = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (w_xfer) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_data_nxt = {r_hi, in_data};
          w_wr_addr_nxt = ADDR_W'(BASE_ADDR) + r_idx;
          w_idx_nxt     = r_idx + 1'b1;
          if (w_idx_p1 == {1'b0, r_len}) w_state_nxt = ST_FINISH;
          else                           w_state_nxt = ST_DATA_HI;
        end
      end
      ST_FINISH: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_in_ready_nxt = (w_state_nxt == ST_LEN_HI)  || (w_state_nxt == ST_LEN_LO) ||
                     (w_state_nxt == ST_DATA_HI) || (w_state_nxt == ST_DATA_LO);
  end

  assign in_ready  = r_in_ready;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign cpu_hold  = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: two loaders (BASE_ADDR 0 and 1020) share one stimulus bus;
// sel picks which one receives start/in_valid and whose outputs are observed.
module tb_im_loader;
  import im_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready0, wr_en0, busy0, hold0, done0, err0;
  logic [9:0] wr_addr0;
  logic [15:0] wr_data0;
  logic [2:0] dbg0;
  logic       in_ready1, wr_en1, busy1, hold1, done1, err1;
  logic [9:0] wr_addr1;
  logic [15:0] wr_data1;
  logic [2:0] dbg1;

  im_loader #(.ADDR_W(10), .BASE_ADDR(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .in_valid(in_valid & ~sel),
    .in_data(in_data), .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .busy(busy0), .cpu_hold(hold0), .done(done0), .err(err0),
    .dbg_state(dbg0));

  im_loader #(.ADDR_W(10), .BASE_ADDR(1020)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .in_valid(in_valid & sel),
    .in_data(in_data), .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .busy(busy1), .cpu_hold(hold1), .done(done1), .err(err1),
    .dbg_state(dbg1));

  logic        m_in_ready, m_wr_en, m_busy, m_hold, m_done, m_err;
  logic [9:0]  m_wr_addr;
  logic [15:0] m_wr_data;
  logic [2:0]  m_dbg;
  assign m_in_ready = sel ? in_ready1 : in_ready0;
  assign m_wr_en    = sel ? wr_en1    : wr_en0;
  assign m_wr_addr  = sel ? wr_addr1  : wr_addr0;
  assign m_wr_data  = sel ? wr_data1  : wr_data0;
  assign m_busy     = sel ? busy1     : busy0;
  assign m_hold     = sel ? hold1     : hold0;
  assign m_done     = sel ? done1     : done0;
  assign m_err      = sel ? err1      : err0;
  assign m_dbg      = sel ? dbg1      : dbg0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_busy = -1;

  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  int          obs_cyc[$];
  int          done_cyc[$];
  logic [15:0] prog_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, away from the registered outputs.
  always @(negedge clk) begin
    if (m_wr_en) begin
      obs_q.push_back({m_wr_addr, m_wr_data});
      obs_cyc.push_back(cyc);
    end
    if (m_done) done_cyc.push_back(cyc);
    if (m_busy) last_busy = cyc;
  end

  // Reference: word i of a legal image lands at base+i; a zero-length or
  // oversized image writes nothing, and oversized sets err.
  task automatic model(input logic s, input int len, output logic e_err);
    int base;
    base = s ? 1020 : 0;
    exp_q.delete();
    if (len > 0 && len <= 1024 - base)
      for (int i = 0; i < len; i++) exp_q.push_back({10'(base + i), prog_q[i]});
    e_err = (len > 1024 - base);
  endtask

  function automatic bit legal_len(input logic s, input int len);
    return (len > 0) && (len <= 1024 - (s ? 1020 : 0));
  endfunction

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic fill_prog(input int n);
    prog_q.delete();
    for (int i = 0; i < n; i++) prog_q.push_back(16'($urandom));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte after a random gap and returns the cycle it transferred.
  task automatic send_byte(input logic [7:0] b, input int maxgap, output int xc);
    int g;
    int k;
    g = $urandom_range(maxgap, 0);
    in_valid = 1'b0;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    k = 0;
    while (!m_in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      total++; bad++;
      $display("FAIL byte_accept_timeout: in_ready stayed %0b, required 1", m_in_ready);
    end
    xc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!m_done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) begin
      total++; bad++;
      $display("FAIL done_timeout: done stayed %0b, required 1", m_done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_load(input logic s, input int len, input int maxgap,
                          output int lo_xc, output int last_xc);
    logic [15:0] l;
    int xc;
    l = 16'(len);
    sel = s;
    pulse_start();
    send_byte(l[15:8], maxgap, xc);
    send_byte(l[7:0], maxgap, lo_xc);
    last_xc = lo_xc;
    if (legal_len(s, len)) begin
      for (int i = 0; i < len; i++) begin
        send_byte(prog_q[i][15:8], maxgap, xc);
        send_byte(prog_q[i][7:0], maxgap, last_xc);
      end
    end
    wait_done();
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      total++;
      if ({m_in_ready, m_wr_en, m_wr_addr, m_wr_data, m_busy, m_hold, m_done, m_err, m_dbg} !== '0) begin
        bad++;
        $display("FAIL reset_values sel=%0d: got rdy=%0b we=%0b a=%0h d=%0h busy=%0b hold=%0b done=%0b err=%0b st=%0d, required all 0",
                 s, m_in_ready, m_wr_en, m_wr_addr, m_wr_data, m_busy, m_hold, m_done, m_err, m_dbg);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_basic();
    int lo_xc, last_xc;
    logic e_err;
    clear_obs();
    prog_q = '{16'h8080, 16'h8404, 16'h08FA};
    model(1'b0, 3, e_err);
    run_load(1'b0, 3, 0, lo_xc, last_xc);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL basic_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL basic_write[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_cyc.size() == 3 && done_cyc.size() == 1) begin
      total++;
      if (obs_cyc[1] - obs_cyc[0] != 2 || obs_cyc[2] - obs_cyc[1] != 2) begin
        bad++; $display("FAIL basic_spacing: write cycles %0d %0d %0d, required step 2", obs_cyc[0], obs_cyc[1], obs_cyc[2]);
      end
      total++;
      if (obs_cyc[2] != last_xc + 1) begin
        bad++; $display("FAIL basic_write_latency: got cycle %0d, required %0d", obs_cyc[2], last_xc + 1);
      end
      total++;
      if (done_cyc[0] != obs_cyc[2] + 1) begin
        bad++; $display("FAIL basic_done_time: got cycle %0d, required %0d", done_cyc[0], obs_cyc[2] + 1);
      end
      total++;
      if (last_busy != done_cyc[0]) begin
        bad++; $display("FAIL basic_busy_drop: last busy cycle %0d, required %0d", last_busy, done_cyc[0]);
      end
    end else begin
      total++; bad++;
      $display("FAIL basic_events: got %0d writes %0d dones, required 3 and 1", obs_cyc.size(), done_cyc.size());
    end
    total++;
    if (m_err !== e_err || m_busy !== 1'b0 || m_hold !== 1'b0) begin
      bad++; $display("FAIL basic_flags: err=%0b busy=%0b hold=%0b, required err=%0b busy=0 hold=0", m_err, m_busy, m_hold, e_err);
    end
  endtask

  task automatic test_zero_len();
    int lo_xc, last_xc;
    logic e_err;
    clear_obs();
    prog_q.delete();
    model(1'b0, 0, e_err);
    run_load(1'b0, 0, 0, lo_xc, last_xc);
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL zero_writes: got %0d writes, required 0", obs_q.size());
    end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != lo_xc + 2) begin
      bad++; $display("FAIL zero_done: got %0d dones first at %0d, required 1 at %0d",
                      done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, lo_xc + 2);
    end
    total++;
    if (m_busy !== 1'b0 || m_err !== e_err) begin
      bad++; $display("FAIL zero_flags: busy=%0b err=%0b, required busy=0 err=%0b", m_busy, m_err, e_err);
    end
  endtask

  task automatic test_overlength();
    int lo_xc, last_xc, xc;
    logic e_err;
    for (int s = 0; s < 2; s++) begin
      clear_obs();
      prog_q.delete();
      model(1'(s), (s == 0) ? 1025 : 5, e_err);
      run_load(1'(s), (s == 0) ? 1025 : 5, 1, lo_xc, last_xc);
      total++;
      if (obs_q.size() != 0 || done_cyc.size() != 1) begin
        bad++; $display("FAIL overlen_events sel=%0d: %0d writes %0d dones, required 0 and 1", s, obs_q.size(), done_cyc.size());
      end
      repeat (4) @(negedge clk);
      total++;
      if (m_err !== e_err) begin
        bad++; $display("FAIL overlen_err_sticky sel=%0d: err=%0b, required %0b", s, m_err, e_err);
      end
      pulse_start();
      total++;
      if (m_err !== 1'b0 || m_busy !== 1'b1) begin
        bad++; $display("FAIL start_clears_err sel=%0d: err=%0b busy=%0b, required err=0 busy=1", s, m_err, m_busy);
      end
      send_byte(8'h00, 0, xc);
      send_byte(8'h00, 0, xc);
      wait_done();
    end
    sel = 1'b0;
  endtask

  task automatic test_gaps();
    int lo_xc, last_xc, xc;
    logic e_err;
    logic [25:0] ref_q[$];
    fill_prog(4);
    model(1'b0, 4, e_err);
    for (int pass = 0; pass < 2; pass++) begin
      clear_obs();
      sel = 1'b0;
      if (pass == 1) begin
        // Offer the first length byte while idle; it must wait for start.
        in_valid = 1'b1;
        in_data = 8'h00;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          total++;
          if (m_in_ready !== 1'b0 || m_dbg !== 3'(ST_IDLE)) begin
            bad++; $display("FAIL idle_no_consume: in_ready=%0b state=%0d, required 0 and idle", m_in_ready, m_dbg);
          end
        end
        pulse_start();
        send_byte(8'h00, 0, xc);
        send_byte(8'h04, 3, lo_xc);
        for (int i = 0; i < 4; i++) begin
          send_byte(prog_q[i][15:8], 3, xc);
          send_byte(prog_q[i][7:0], 3, xc);
        end
        wait_done();
      end else begin
        run_load(1'b0, 4, 0, lo_xc, last_xc);
        ref_q = obs_q;
      end
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++; $display("FAIL gaps_count pass=%0d: got %0d writes, required %0d", pass, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL gaps_write[%0d] pass=%0d: got %h, required %h", i, pass, obs_q[i], exp_q[i]);
        end
      end
    end
    total++;
    if (obs_q != ref_q) begin
      bad++; $display("FAIL gaps_vs_gapfree: got %0d writes, gap-free run had %0d", obs_q.size(), ref_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    int xc, lo_xc, last_xc;
    logic e_err;
    clear_obs();
    sel = 1'b0;
    fill_prog(5);
    pulse_start();
    send_byte(8'h00, 0, xc);
    send_byte(8'h05, 0, xc);
    for (int i = 0; i < 2; i++) begin
      send_byte(prog_q[i][15:8], 0, xc);
      send_byte(prog_q[i][7:0], 0, xc);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({m_in_ready, m_wr_en, m_wr_addr, m_wr_data, m_busy, m_hold, m_done, m_err, m_dbg} !== '0) begin
      bad++;
      $display("FAIL reset_mid_load: rdy=%0b we=%0b a=%0h d=%0h busy=%0b hold=%0b done=%0b err=%0b st=%0d, required all 0",
               m_in_ready, m_wr_en, m_wr_addr, m_wr_data, m_busy, m_hold, m_done, m_err, m_dbg);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (done_cyc.size() != 0 || obs_q.size() != 2) begin
      bad++; $display("FAIL reset_mid_events: %0d dones %0d writes, required 0 and 2", done_cyc.size(), obs_q.size());
    end
    clear_obs();
    fill_prog(1);
    model(1'b0, 1, e_err);
    run_load(1'b0, 1, 0, lo_xc, last_xc);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL reload_after_reset: got %0d writes first %h, required 1 write %h",
                      obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 26'h0, exp_q[0]);
    end
  endtask

  task automatic test_mid_start_base();
    int lo_xc, last_xc;
    logic e_err;
    clear_obs();
    fill_prog(4);
    model(1'b1, 4, e_err);
    fork
      run_load(1'b1, 4, 0, lo_xc, last_xc);
      begin
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    total++;
    if (obs_q.size() != 4 || done_cyc.size() != 1) begin
      bad++; $display("FAIL midstart_events: %0d writes %0d dones, required 4 and 1", obs_q.size(), done_cyc.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL midstart_write[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (m_err !== e_err || m_in_ready !== 1'b0 || m_busy !== 1'b0) begin
      bad++; $display("FAIL midstart_flags: err=%0b rdy=%0b busy=%0b, required err=%0b rdy=0 busy=0", m_err, m_in_ready, m_busy, e_err);
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    int lo_xc, last_xc, len, mism;
    logic s, e_err;
    for (int t = 0; t < 7; t++) begin
      clear_obs();
      s = (t == 6) ? 1'b0 : 1'($urandom_range(1, 0));
      len = (t == 6) ? 1024 : (s ? $urandom_range(4, 1) : $urandom_range(12, 1));
      fill_prog(len);
      model(s, len, e_err);
      run_load(s, len, (t == 6) ? 0 : 2, lo_xc, last_xc);
      mism = 0;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
        if (obs_q[i] !== exp_q[i]) mism++;
      total++;
      if (obs_q.size() != exp_q.size() || mism != 0 || done_cyc.size() != 1 || m_err !== e_err) begin
        bad++;
        $display("FAIL random_load t=%0d sel=%0b n=%0d: %0d writes (%0d wrong) %0d dones err=%0b, required %0d writes 1 done err=%0b",
                 t, s, len, obs_q.size(), mism, done_cyc.size(), m_err, exp_q.size(), e_err);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_zero_len();
    test_overlength();
    test_gaps();
    test_reset_mid_load();
    test_mid_start_base();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
